fc3l_pwm_gen: RTL and testbench
===============================

// Module: fc3l_pwm_gen
// PURPOSE
//   Phase-shifted PWM modulator with dead-time for one 3-level flying-capacitor leg.
//   Two triangular carriers 180 deg apart drive two complementary switch pairs (outer S1/S1c, inner S2/S2c).
//   Sits inside top, between the duty source (I2C/control loop) and the pwm_o pins; top instantiates two (pwm_o[3:0], pwm_o[7:4]).
// PARAMETERS
//   CNT_W   10   carrier counter width
//   PERIOD  540  carrier peak; switching period = 2*PERIOD clk (25 kHz @ 27 MHz)
//   DT      14   dead-time in clk cycles (~0.52 us); 1 <= DT < 2^DT_W
//   DT_W    5    dead-time counter width
// PORTS
//   clk_i         in   1      system clock, 27 MHz
//   rst_i         in   1      asynchronous reset, active-high
//   en_i          in   1      modulator enable; low = all switches off, fault cleared
//   fault_i       in   1      hard fault; forces all switches off (latched)
//   duty_i        in   CNT_W  requested duty, 0..PERIOD (larger values clamped to PERIOD)
//   duty_valid_i  in   1      duty_i valid
//   duty_ready_o  out  1      pending slot empty; duty accepted on valid&ready
//   pwm_o         out  4      [0]=S1 [1]=S1c [2]=S2 [3]=S2c, registered
//   sync_o        out  1      1-cycle pulse when carrier A = 0 (period start)
//   fault_o       out  1      latched fault flag
// BEHAVIOUR
//   Reset: pwm_o=0, sync_o=0, fault_o=0, duty_ready_o=1, cnt=0, dir=up, duty_act=0, pending empty, legs OFF.
//   Carrier A: en_i=1 -> 0,1..PERIOD,PERIOD-1..1,0,1..; dir flips at PERIOD and at 0. en_i=0 -> cnt held 0, dir=up.
//   Carrier B = PERIOD - cnt (combinational). sync_o = en_i & (cnt==0), registered.
//   Duty: valid&ready -> clamp(duty_i) into pending, ready drops next cycle.
//     At cnt==0 with en_i=1: pending -> duty_act, ready rises next cycle. Update only at bottom.
//     Acceptance in the same cycle as the bottom -> applied at the next bottom.
//   Raw refs: rawA = (duty_act!=0) & (duty_act>=cntA); rawB same with cntB. duty=0 -> never high; duty=PERIOD -> always high.
//   Leg FSM, one per pair (A->S1/S1c, B->S2/S2c), states OFF, LO_ON, DEAD, HI_ON:
//     OFF:   both off; en_i&~fault_o -> DEAD, dt_cnt=DT.
//     LO_ON: comp on; raw=1 -> DEAD, dt_cnt=DT (comp off next cycle).
//     HI_ON: main on; raw=0 -> DEAD, dt_cnt=DT.
//     DEAD:  both off for DT cycles, decrement; at 0 -> HI_ON if raw else LO_ON (raw sampled at exit, glitches inside DEAD ignored).
//     Any state: ~en_i or fault_o -> OFF next cycle.
//   Outputs are registered from state: 1-cycle latency from raw edge to turn-off edge, DT+1 to turn-on edge.
//   Invariant: pwm_o[0]&pwm_o[1] and pwm_o[2]&pwm_o[3] are never 1, including at reset, enable and fault.
//   Fault: fault_i=1 -> fault_o=1 and pwm_o=0 next edge. Held while en_i=1 even if fault_i drops. en_i=0 clears it.
//   Enable rise: carrier starts from 0 up. Legs spend DT cycles in DEAD before first on-state.
//   Disable mid-period: outputs 0 next edge. Pending duty kept. duty_act kept.
//   Async reset mid-operation: all outputs 0 immediately, no clock needed.
// TESTING (bench PERIOD=8, DT=2, CNT_W=4, DT_W=2)
//   Reset then en_i=1, duty 4 loaded -> per 16-cycle period: S1 on 7, S1c on 5, both off 2x2. S2 same, shifted 8 cycles. Never overlap.
//   Duty 0 -> S1,S2 never high; S1c,S2c constant high after initial DT.
//   Duty 8 -> S1,S2 constant high. Duty 12 is clamped and behaves as 8.
//   Duty 2 then 6 sent back-to-back -> 2nd held off by duty_ready_o=0. 6 applied one period after 2. sync_o pulses every 16 cycles.
//   fault_i 1-cycle pulse mid-period -> pwm_o=0 next edge, fault_o stays 1. en_i low -> fault_o=0. Re-enable -> DT off, then normal.
//   rst_i asserted with S1 high -> pwm_o=0 immediately. duty_ready_o=1, sync_o=0 while held.

Source files
------------

// File: rtl/fc3l_pwm_gen.sv
// Phase-shifted PWM modulator with dead-time for one 3-level flying-capacitor leg.
// Carrier A is an up/down triangle; carrier B is its mirror (PERIOD - A), giving
// the 180 deg phase shift between the outer (S1/S1c) and inner (S2/S2c) pairs.
//
// Leg FSM (one per switch pair):
//   state | meaning
//   OFF   | both switches off; modulator disabled or faulted
//   LO_ON | complementary switch on, main off
//   DEAD  | both off while the dead-time down-counter runs out
//   HI_ON | main switch on, complementary off
module fc3l_pwm_gen #(
  parameter int CNT_W  = 10,
  parameter int PERIOD = 540,
  parameter int DT     = 14,
  parameter int DT_W   = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             fault_i,
  input  logic [CNT_W-1:0] duty_i,
  input  logic             duty_valid_i,
  output logic             duty_ready_o,
  output logic [3:0]       pwm_o,
  output logic             sync_o,
  output logic             fault_o
);

  localparam logic [CNT_W-1:0] PERIOD_C = CNT_W'(PERIOD);
  localparam logic [DT_W-1:0]  DT_C     = DT_W'(DT);

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    LO_ON = 2'd1,
    DEAD  = 2'd2,
    HI_ON = 2'd3
  } leg_state_e;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_up_q, dir_up_d;
  logic [CNT_W-1:0] cnt_b;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             pend_v_q, pend_v_d;
  logic [CNT_W-1:0] act_q, act_d;
  logic [CNT_W-1:0] duty_clamped;
  logic             sync_q, sync_d;
  logic             fault_q, fault_d;
  logic             bottom;
  logic             kill;
  logic [1:0]       raw;
  logic [3:0]       pwm_q, pwm_d;

  assign cnt_b        = PERIOD_C - cnt_q;
  assign bottom       = en_i & (cnt_q == '0);
  assign duty_clamped = (duty_i > PERIOD_C) ? PERIOD_C : duty_i;

  // Zero duty must never turn the main switch on, even at the carrier bottom.
  assign raw[0] = (act_q != '0) & (act_q >= cnt_q);
  assign raw[1] = (act_q != '0) & (act_q >= cnt_b);

  // A fault pulse kills the legs on the very next edge, before fault_q is visible.
  assign kill = ~en_i | fault_i | fault_q;

  // Carrier A: triangle 0..PERIOD..0, parked at the bottom counting up while disabled.
  always_comb begin
    cnt_d    = cnt_q;
    dir_up_d = dir_up_q;
    if (!en_i) begin
      cnt_d    = '0;
      dir_up_d = 1'b1;
    end else if (dir_up_q) begin
      if (cnt_q >= PERIOD_C) begin
        cnt_d    = cnt_q - CNT_W'(1);
        dir_up_d = 1'b0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      if (cnt_q == '0) begin
        cnt_d    = CNT_W'(1);
        dir_up_d = 1'b1;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // Duty handshake: one pending slot, promoted to the active duty only at the bottom.
  always_comb begin
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    act_d    = act_q;
    if (bottom && pend_v_q) begin
      act_d    = pend_q;
      pend_v_d = 1'b0;
    end else if (duty_valid_i && !pend_v_q) begin
      pend_d   = duty_clamped;
      pend_v_d = 1'b1;
    end
  end

  // Period-start pulse and fault latch; dropping enable is the only way to clear a fault.
  always_comb begin
    sync_d  = bottom;
    fault_d = en_i & (fault_q | fault_i);
  end

  // Shared sequential state for carrier, duty path and flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      dir_up_q <= 1'b1;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      act_q    <= '0;
      sync_q   <= 1'b0;
      fault_q  <= 1'b0;
      pwm_q    <= '0;
    end else begin
      cnt_q    <= cnt_d;
      dir_up_q <= dir_up_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      act_q    <= act_d;
      sync_q   <= sync_d;
      fault_q  <= fault_d;
      pwm_q    <= pwm_d;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_leg
    leg_state_e      st_q, st_d;
    logic [DT_W-1:0] dt_q, dt_d, dt_dec;

    assign dt_dec = dt_q - DT_W'(1);

    // Leg next-state: every turn-on passes through DEAD; raw is only looked at on exit.
    always_comb begin
      st_d = st_q;
      dt_d = dt_q;
      if (kill) begin
        st_d = OFF;
        dt_d = '0;
      end else begin
        unique case (st_q)
          OFF: begin
            st_d = DEAD;
            dt_d = DT_C;
          end
          LO_ON: begin
            if (raw[g]) begin
              st_d = DEAD;
              dt_d = DT_C;
            end
          end
          HI_ON: begin
            if (!raw[g]) begin
              st_d = DEAD;
              dt_d = DT_C;
            end
          end
          DEAD: begin
            dt_d = dt_dec;
            if (dt_dec == '0) st_d = raw[g] ? HI_ON : LO_ON;
          end
          default: begin
            st_d = OFF;
            dt_d = '0;
          end
        endcase
      end
    end

    // Leg state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        st_q <= OFF;
        dt_q <= '0;
      end else begin
        st_q <= st_d;
        dt_q <= dt_d;
      end
    end

    // Each pair is decoded from a single state, so main and comp can never overlap.
    assign pwm_d[2*g]   = (st_d == HI_ON);
    assign pwm_d[2*g+1] = (st_d == LO_ON);
  end

  assign duty_ready_o = ~pend_v_q;
  assign pwm_o        = pwm_q;
  assign sync_o       = sync_q;
  assign fault_o      = fault_q;

endmodule

// File: tb/tb_fc3l_pwm_gen.sv
// Bench for fc3l_pwm_gen: directed scenarios followed by randomized duty/enable/fault
// traffic, all compared every cycle against a behavioural model of the leg.
module tb_fc3l_pwm_gen;

  localparam int CNT_W  = 4;
  localparam int PERIOD = 8;
  localparam int DT     = 2;
  localparam int DT_W   = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             flt;
  logic [CNT_W-1:0] duty;
  logic             valid;
  logic             ready;
  logic [3:0]       pwm;
  logic             sync;
  logic             fault_o;

  always #5 clk = ~clk;

  fc3l_pwm_gen #(.CNT_W(CNT_W), .PERIOD(PERIOD), .DT(DT), .DT_W(DT_W)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .en_i         (en),
    .fault_i      (flt),
    .duty_i       (duty),
    .duty_valid_i (valid),
    .duty_ready_o (ready),
    .pwm_o        (pwm),
    .sync_o       (sync),
    .fault_o      (fault_o)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference model state. Carrier is a closed-form triangle of the enabled-cycle count;
  // each leg output is a window rule: main on only if raw has been high for the last
  // DT+1 cycles, comp on only if low for the last DT+1 cycles. History before the end
  // of the enable dead-time is taken to equal the raw sampled at that moment.
  int       m_k, m_age, m_pend, m_act;
  bit       m_pend_v, m_fault, m_sync, m_ready;
  bit [3:0] m_pwm;
  bit       hist_a [DT+1];
  bit       hist_b [DT+1];

  bit en_r, flt_r;
  int src_q[$];
  bit tally;
  int n_s [4];
  int n_sync;

  function automatic int tri_wave(input int k);
    int m;
    m = k % (2 * PERIOD);
    return (m <= PERIOD) ? m : 2 * PERIOD - m;
  endfunction

  task automatic model_reset();
    m_k = 0; m_age = 0; m_pend = 0; m_act = 0;
    m_pend_v = 0; m_fault = 0; m_sync = 0; m_ready = 1; m_pwm = '0;
    for (int i = 0; i <= DT; i++) begin
      hist_a[i] = 0;
      hist_b[i] = 0;
    end
  endtask

  task automatic model_step(input bit en_in, input bit flt_in, input bit vld_in,
                            input int duty_in, output bit accepted);
    int cnt;
    bit ra, rb, alive, a_hi, a_lo, b_hi, b_lo;
    cnt   = tri_wave(m_k);
    ra    = (m_act != 0) && (m_act >= cnt);
    rb    = (m_act != 0) && (m_act >= PERIOD - cnt);
    alive = en_in && !flt_in && !m_fault;
    accepted = vld_in && !m_pend_v;
    m_sync  = en_in && (cnt == 0);
    m_fault = en_in && (m_fault || flt_in);
    m_age   = !alive ? 0 : (m_age >= DT + 1) ? DT + 2 : m_age + 1;
    if (m_age <= DT) begin
      m_pwm = '0;
    end else begin
      if (m_age == DT + 1) begin
        for (int i = 0; i <= DT; i++) begin
          hist_a[i] = ra;
          hist_b[i] = rb;
        end
      end else begin
        for (int i = DT; i > 0; i--) begin
          hist_a[i] = hist_a[i-1];
          hist_b[i] = hist_b[i-1];
        end
        hist_a[0] = ra;
        hist_b[0] = rb;
      end
      a_hi = 1; a_lo = 1; b_hi = 1; b_lo = 1;
      for (int i = 0; i <= DT; i++) begin
        a_hi &= hist_a[i];  a_lo &= !hist_a[i];
        b_hi &= hist_b[i];  b_lo &= !hist_b[i];
      end
      m_pwm = {b_lo, b_hi, a_lo, a_hi};
    end
    if (en_in && cnt == 0 && m_pend_v) begin
      m_act    = m_pend;
      m_pend_v = 0;
    end else if (accepted) begin
      m_pend   = (duty_in > PERIOD) ? PERIOD : duty_in;
      m_pend_v = 1;
    end
    m_ready = !m_pend_v;
    m_k = en_in ? (m_k + 1) % (2 * PERIOD) : 0;
  endtask

  // One clock: compare outputs, then drive this cycle's inputs and advance the model.
  task automatic cycle();
    bit acc;
    int d;
    @(negedge clk);
    check("pwm", int'(pwm), int'(m_pwm));
    check("sync", int'(sync), int'(m_sync));
    check("fault", int'(fault_o), int'(m_fault));
    check("ready", int'(ready), int'(m_ready));
    check("overlap", int'({pwm[2] & pwm[3], pwm[0] & pwm[1]}), 0);
    if (tally) begin
      for (int i = 0; i < 4; i++) n_s[i] += int'(pwm[i]);
      n_sync += int'(sync);
    end
    en    = en_r;
    flt   = flt_r;
    flt_r = 0;
    valid = (src_q.size() > 0);
    d     = valid ? src_q[0] : int'($urandom_range(0, 15));
    duty  = CNT_W'(d);
    model_step(en_r, flt, valid, d, acc);
    if (acc) void'(src_q.pop_front());
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic count_window(input int n);
    for (int i = 0; i < 4; i++) n_s[i] = 0;
    n_sync = 0;
    tally  = 1;
    run(n);
    tally  = 0;
  endtask

  int dset [7] = '{0, 3, 4, 8, 9, 12, 15};
  int off_left;

  initial begin
    rst = 1; en = 0; flt = 0; valid = 0; duty = '0;
    en_r = 0; flt_r = 0; tally = 0; off_left = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_pwm", int'(pwm), 0);
    check("rst_sync", int'(sync), 0);
    check("rst_fault", int'(fault_o), 0);
    check("rst_ready", int'(ready), 1);
    rst = 0;

    // 2 then 6 back-to-back while disabled: 6 waits for the slot, lands a period later.
    src_q.push_back(2);
    src_q.push_back(6);
    run(3);
    en_r = 1;
    run(40);

    // Duty 4 steady state: per 16-cycle period S1 on 7, S1c on 5, same for S2/S2c.
    src_q.push_back(4);
    run(40);
    count_window(32);
    check("d4_s1", n_s[0], 14);
    check("d4_s1c", n_s[1], 10);
    check("d4_s2", n_s[2], 14);
    check("d4_s2c", n_s[3], 10);
    check("d4_sync", n_sync, 2);

    src_q.push_back(0);
    run(40);
    count_window(32);
    check("d0_s1", n_s[0], 0);
    check("d0_s1c", n_s[1], 32);
    check("d0_s2", n_s[2], 0);
    check("d0_s2c", n_s[3], 32);

    src_q.push_back(8);
    run(40);
    count_window(32);
    check("d8_s1", n_s[0], 32);
    check("d8_s2", n_s[2], 32);

    src_q.push_back(12);
    run(40);
    count_window(32);
    check("d12_s1", n_s[0], 32);
    check("d12_s1c", n_s[1], 0);
    check("d12_s2", n_s[2], 32);
    check("d12_s2c", n_s[3], 0);

    // Fault pulse mid-period, latch held until enable drops, then restart through dead-time.
    run(5);
    flt_r = 1;
    run(12);
    check("flt_hold", int'(fault_o), 1);
    check("flt_pwm", int'(pwm), 0);
    en_r = 0;
    run(3);
    check("flt_clear", int'(fault_o), 0);
    en_r = 1;
    run(2);
    check("reen_dead", int'(pwm), 0);
    run(2);
    check("reen_on", int'(pwm), 5);

    // Random traffic. Duty values avoid raw pulses shorter than the dead-time window.
    for (int c = 0; c < 700; c++) begin
      if (src_q.size() == 0 && $urandom_range(0, 23) == 0)
        src_q.push_back(dset[$urandom_range(0, 6)]);
      if ($urandom_range(0, 299) == 0) flt_r = 1;
      if (off_left > 0) begin
        off_left--;
        en_r = (off_left == 0);
      end else if ($urandom_range(0, m_fault ? 19 : 149) == 0) begin
        off_left = $urandom_range(1, 6);
        en_r = 0;
      end
      cycle();
    end

    // Bring S1 high, then hit async reset between clock edges.
    en_r = 0;
    run(2);
    en_r = 1;
    src_q.push_back(8);
    run(40);
    check("pre_rst_s1", int'(pwm[0]), 1);
    @(negedge clk);
    #1 rst = 1;
    #1;
    check("async_rst_pwm", int'(pwm), 0);
    check("async_rst_fault", int'(fault_o), 0);
    repeat (3) begin
      @(negedge clk);
      check("hold_ready", int'(ready), 1);
      check("hold_sync", int'(sync), 0);
      check("hold_pwm", int'(pwm), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
